// File: rtl/mem_port_arbiter_if.sv
// Downstream sram-like memory port shared by the instruction and data requesters.
//   master : the arbiter (drives request, write flag, strobes, address, write data)
//   slave  : the memory bridge (drives addr_ok, data_ok, read data)
// Handshake: a request is held with stable fields while mem_req=1 until the
// cycle mem_addr_ok=1 (accepted); mem_data_ok=1 later (or in that same cycle)
// marks read data valid / write done. mem_req is never withdrawn before accept.
interface mem_port_arbiter_if;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data load/store.
// Data has priority; after DATA_BURST consecutive data grants while fetch is
// waiting, the next grant goes to fetch. One access is in flight at a time and
// the arbiter always spends at least one IDLE cycle between accesses.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               pipeline flush (blocks fetch grant, discards fetch in flight)
//   inst_*              fetch request side: req/addr in, rdata/done/fetch_available out
//   data_*              data request side: req/wen/addr/wdata in, rdata/done/memory_available out
//   mem                 downstream port (master side of mem_port_arbiter_if)
//   dbg_state           current FSM state, for observation only
module mem_port_arbiter #(
  parameter int unsigned DATA_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      inst_req,
  input  logic [31:0]               inst_addr,
  output logic [31:0]               inst_rdata,
  output logic                      inst_done,
  output logic                      fetch_available,
  input  logic                      data_req,
  input  logic [3:0]                data_wen,
  input  logic [31:0]               data_addr,
  input  logic [31:0]               data_wdata,
  output logic [31:0]               data_rdata,
  output logic                      data_done,
  output logic                      memory_available,
  mem_port_arbiter_if.master        mem,
  output logic [2:0]                dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE_D = 3'd1;
  localparam logic [2:0] S_ISSUE_I = 3'd2;
  localparam logic [2:0] S_WAIT_D  = 3'd3;
  localparam logic [2:0] S_WAIT_I  = 3'd4;

  localparam int BW = $clog2(DATA_BURST + 1);

  logic [2:0]    state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          discard_q, discard_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    wen_q, wen_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   inst_rdata_q, inst_rdata_d;
  logic [31:0]   data_rdata_q, data_rdata_d;
  logic          inst_done_q, inst_done_d;
  logic          data_done_q, data_done_d;
  logic          fetch_av_q, fetch_av_d;
  logic          mem_av_q, mem_av_d;

  logic issuing;
  logic waiting;
  logic inst_txn;
  logic complete;

  assign issuing  = (state_q == S_ISSUE_D) || (state_q == S_ISSUE_I);
  assign waiting  = (state_q == S_WAIT_D)  || (state_q == S_WAIT_I);
  assign inst_txn = (state_q == S_ISSUE_I) || (state_q == S_WAIT_I);
  // data_ok only counts once the request has been (or is being) accepted.
  assign complete = (issuing && mem.mem_addr_ok && mem.mem_data_ok) ||
                    (waiting && mem.mem_data_ok);

  always_comb begin
    state_d      = state_q;
    burst_d      = burst_q;
    discard_d    = discard_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_done_d  = 1'b0;
    data_done_d  = 1'b0;
    fetch_av_d   = fetch_av_q;
    mem_av_d     = mem_av_q;

    case (state_q)
      S_IDLE: begin
        if (data_req && (!inst_req || (burst_q < BW'(DATA_BURST)))) begin
          state_d  = S_ISSUE_D;
          addr_d   = data_addr;
          wen_d    = data_wen;
          wdata_d  = data_wdata;
          // The streak only counts grants that made a fetch wait.
          burst_d  = inst_req ? (burst_q + BW'(1)) : '0;
          mem_av_d = 1'b0;
        end else if (inst_req && !flush) begin
          state_d    = S_ISSUE_I;
          addr_d     = inst_addr;
          wen_d      = 4'b0000;
          wdata_d    = 32'h0;
          burst_d    = '0;
          fetch_av_d = 1'b0;
        end
      end
      S_ISSUE_D, S_ISSUE_I: begin
        if (mem.mem_addr_ok) begin
          if (mem.mem_data_ok)
            state_d = S_IDLE;
          else
            state_d = (state_q == S_ISSUE_D) ? S_WAIT_D : S_WAIT_I;
        end
      end
      S_WAIT_D, S_WAIT_I: begin
        if (mem.mem_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      if (inst_txn) begin
        fetch_av_d = 1'b1;
        discard_d  = 1'b0;
        // A flush in the completing cycle discards just like an earlier one.
        if (!(discard_q || flush)) begin
          inst_done_d  = 1'b1;
          inst_rdata_d = mem.mem_rdata;
        end
      end else begin
        mem_av_d    = 1'b1;
        data_done_d = 1'b1;
        if (wen_q == 4'b0000) data_rdata_d = mem.mem_rdata;
      end
    end else if (inst_txn && flush) begin
      discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      burst_q      <= '0;
      discard_q    <= 1'b0;
      addr_q       <= 32'h0;
      wen_q        <= 4'b0000;
      wdata_q      <= 32'h0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      fetch_av_q   <= 1'b1;
      mem_av_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      discard_q    <= discard_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      fetch_av_q   <= fetch_av_d;
      mem_av_q     <= mem_av_d;
    end
  end

  // Fetches register wen=0 and wdata=0, so write fields are naturally idle for them.
  assign mem.mem_req   = issuing;
  assign mem.mem_wr    = (state_q == S_ISSUE_D) && (wen_q != 4'b0000);
  assign mem.mem_wstrb = issuing ? wen_q   : 4'b0000;
  assign mem.mem_addr  = issuing ? addr_q  : 32'h0;
  assign mem.mem_wdata = issuing ? wdata_q : 32'h0;

  assign inst_rdata       = inst_rdata_q;
  assign inst_done        = inst_done_q;
  assign fetch_available  = fetch_av_q;
  assign data_rdata       = data_rdata_q;
  assign data_done        = data_done_q;
  assign memory_available = mem_av_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        flush = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = 32'h0;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        fetch_available;
  logic        data_req = 1'b0;
  logic [3:0]  data_wen = 4'b0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        memory_available;
  logic [2:0]  dbg_state;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.DATA_BURST(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_done(inst_done), .fetch_available(fetch_available),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done),
    .memory_available(memory_available),
    .mem(bus),
    .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- downstream responder ----------------
  // Accepts after addr_delay cycles of mem_req, answers data_delay cycles
  // after accept (0 = same cycle). Read data is poisoned outside data_ok.
  int          addr_delay = 0;
  int          data_delay = 1;
  logic [31:0] resp_rdata = 32'h0;
  int          r_phase = 0;
  int          r_cnt = 0;

  always @(negedge clk) begin
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = 32'hBAD0_BAD0;
    if (rst) begin
      r_phase = 0;
      r_cnt   = 0;
    end else if (r_phase == 0) begin
      if (bus.mem_req) begin
        if (r_cnt >= addr_delay) begin
          bus.mem_addr_ok = 1'b1;
          r_cnt = 0;
          if (data_delay == 0) begin
            bus.mem_data_ok = 1'b1;
            bus.mem_rdata   = resp_rdata;
          end else begin
            r_phase = 1;
            r_cnt   = 1;
          end
        end else begin
          r_cnt++;
        end
      end
    end else begin
      if (r_cnt >= data_delay) begin
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = resp_rdata;
        r_phase = 0;
        r_cnt   = 0;
      end else begin
        r_cnt++;
      end
    end
  end

  // ---------------- transaction-level model ----------------
  // One record for the access in flight; expected outputs follow from the
  // arbitration rules applied to inputs seen at each clock edge.
  bit          model_ready = 0;
  bit          m_busy = 0, m_is_inst = 0, m_acc = 0, m_disc = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [3:0]  m_wen = 0;
  int          m_streak = 0;
  bit          m_grants[$];           // 1 = instruction grant, 0 = data grant
  logic        e_inst_done = 0, e_data_done = 0, e_fetch_av = 1, e_mem_av = 1;
  logic [31:0] e_inst_rdata = 0, e_data_rdata = 0;

  always @(posedge clk) begin
    bit fin;
    if (rst) begin
      m_busy = 0; m_acc = 0; m_disc = 0; m_streak = 0;
      e_inst_done = 0; e_data_done = 0; e_fetch_av = 1; e_mem_av = 1;
      e_inst_rdata = 0; e_data_rdata = 0;
    end else begin
      e_inst_done = 0;
      e_data_done = 0;
      if (m_busy) begin
        fin = bus.mem_data_ok && (m_acc || bus.mem_addr_ok);
        if (m_is_inst && flush) m_disc = 1;
        if (fin) begin
          if (m_is_inst) begin
            e_fetch_av = 1;
            if (!m_disc) begin e_inst_done = 1; e_inst_rdata = bus.mem_rdata; end
          end else begin
            e_mem_av = 1;
            e_data_done = 1;
            if (m_wen == 4'b0) e_data_rdata = bus.mem_rdata;
          end
          m_busy = 0; m_acc = 0; m_disc = 0;
        end else if (bus.mem_addr_ok) begin
          m_acc = 1;
        end
      end else if (data_req && (!inst_req || m_streak < 4)) begin
        m_busy = 1; m_is_inst = 0; m_addr = data_addr; m_wen = data_wen; m_wdata = data_wdata;
        m_streak = inst_req ? m_streak + 1 : 0;
        e_mem_av = 0;
        m_grants.push_back(1'b0);
      end else if (inst_req && !flush) begin
        m_busy = 1; m_is_inst = 1; m_addr = inst_addr; m_wen = 4'b0; m_wdata = 0;
        m_streak = 0;
        e_fetch_av = 0;
        m_grants.push_back(1'b1);
      end
    end
    model_ready = 1;
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    logic e_req, e_wr;
    #2;
    if (model_ready) begin
      e_req = m_busy && !m_acc;
      e_wr  = e_req && !m_is_inst && (m_wen != 4'b0);
      chk("inst_done",        32'(inst_done),        32'(e_inst_done));
      chk("data_done",        32'(data_done),        32'(e_data_done));
      chk("fetch_available",  32'(fetch_available),  32'(e_fetch_av));
      chk("memory_available", 32'(memory_available), 32'(e_mem_av));
      chk("inst_rdata",       inst_rdata,            e_inst_rdata);
      chk("data_rdata",       data_rdata,            e_data_rdata);
      chk("mem_req",          32'(bus.mem_req),      32'(e_req));
      chk("mem_wr",           32'(bus.mem_wr),       32'(e_wr));
      chk("mem_wstrb",        32'(bus.mem_wstrb),    (e_req && !m_is_inst) ? 32'(m_wen) : 32'h0);
      if (e_req) chk("mem_addr", bus.mem_addr, m_addr);
      if (e_wr)  chk("mem_wdata", bus.mem_wdata, m_wdata);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  bit got[$];
  bit exp_order[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int base;
    int seen;
    bit prev_req;

    // reset
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_fetch_av", 32'(fetch_available), 32'd1);
    chk("rst_mem_av",   32'(memory_available), 32'd1);
    chk("rst_mem_req",  32'(bus.mem_req), 32'd0);
    chk("rst_inst_rd",  inst_rdata, 32'h0);
    chk("rst_state",    32'(dbg_state), 32'd0);

    // single instruction read
    addr_delay = 0; data_delay = 1; resp_rdata = 32'h3C08_0001;
    inst_req = 1'b1; inst_addr = 32'h1FC0_0000;
    step(); inst_req = 1'b0;
    chk("t1_mem_req",  32'(bus.mem_req), 32'd1);
    chk("t1_mem_addr", bus.mem_addr, 32'h1FC0_0000);
    chk("t1_mem_wr",   32'(bus.mem_wr), 32'd0);
    chk("t1_fav_n1",   32'(fetch_available), 32'd0);
    step();
    chk("t1_fav_n2",   32'(fetch_available), 32'd0);
    step();
    chk("t1_done",     32'(inst_done), 32'd1);
    chk("t1_rdata",    inst_rdata, 32'h3C08_0001);
    chk("t1_fav_n3",   32'(fetch_available), 32'd1);

    // load then store (store granted in the load's done cycle)
    resp_rdata = 32'hCAFE_F00D;
    data_req = 1'b1; data_wen = 4'b0000; data_addr = 32'h0000_2000; data_wdata = 32'h0;
    step(); data_req = 1'b0;
    chk("t2_ld_wr",    32'(bus.mem_wr), 32'd0);
    chk("t2_ld_mav",   32'(memory_available), 32'd0);
    step(); step();
    chk("t2_ld_done",  32'(data_done), 32'd1);
    chk("t2_ld_rdata", data_rdata, 32'hCAFE_F00D);
    resp_rdata = 32'h1234_5678;
    data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h0000_1004; data_wdata = 32'hDEAD_BEEF;
    step(); data_req = 1'b0;
    chk("t2_st_wr",    32'(bus.mem_wr), 32'd1);
    chk("t2_st_wstrb", 32'(bus.mem_wstrb), 32'h3);
    chk("t2_st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("t2_st_addr",  bus.mem_addr, 32'h0000_1004);
    step(); step();
    chk("t2_st_done",  32'(data_done), 32'd1);
    chk("t2_st_rdata", data_rdata, 32'hCAFE_F00D);

    // contention with 1-cycle downstream
    addr_delay = 0; data_delay = 0; resp_rdata = 32'h55AA_55AA;
    base = m_grants.size();
    inst_req = 1'b1; inst_addr = 32'h1FC0_0020;
    data_req = 1'b1; data_wen = 4'b0; data_addr = 32'h0000_2004;
    prev_req = 1'b0;
    for (int i = 0; i < 40 && got.size() < 6; i++) begin
      step();
      if (bus.mem_req && !prev_req) got.push_back(bus.mem_addr == 32'h1FC0_0020);
      prev_req = bus.mem_req;
    end
    inst_req = 1'b0; data_req = 1'b0;
    chk("t3_grant_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_dut_order%0d", i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));
      chk($sformatf("t3_model_order%0d", i), (base + i < m_grants.size()) ? 32'(m_grants[base + i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));
    end
    repeat (3) step();

    // flush while waiting for fetch data
    data_delay = 3; resp_rdata = 32'h9999_9999;
    inst_req = 1'b1; inst_addr = 32'h1FC0_0010;
    step(); inst_req = 1'b0;
    step(); flush = 1'b1;
    step(); flush = 1'b0;
    step();
    chk("t4_fav_wait", 32'(fetch_available), 32'd0);
    step();
    chk("t4_no_done",  32'(inst_done), 32'd0);
    chk("t4_rdata",    inst_rdata, 32'h55AA_55AA);
    chk("t4_fav_back", 32'(fetch_available), 32'd1);
    // fetch request during a flush cycle is held off, then granted
    data_delay = 1; resp_rdata = 32'h3C08_0002;
    inst_req = 1'b1; inst_addr = 32'h1FC0_0014; flush = 1'b1;
    step(); flush = 1'b0;
    chk("t4_flush_block", 32'(bus.mem_req), 32'd0);
    step(); inst_req = 1'b0;
    chk("t4_regrant", 32'(bus.mem_req), 32'd1);
    step(); step();
    chk("t4_done",  32'(inst_done), 32'd1);
    chk("t4_rdata2", inst_rdata, 32'h3C08_0002);

    // delayed addr_ok with data request arriving meanwhile
    addr_delay = 5; data_delay = 1; resp_rdata = 32'h0F0F_0F0F;
    inst_req = 1'b1; inst_addr = 32'h1FC0_0030;
    step(); inst_req = 1'b0;
    data_req = 1'b1; data_wen = 4'b0; data_addr = 32'h0000_3000;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_req_hold%0d", i), 32'(bus.mem_req), 32'd1);
      chk($sformatf("t5_addr_hold%0d", i), bus.mem_addr, 32'h1FC0_0030);
      step();
    end
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      if (inst_done) seen = 1; else step();
    end
    chk("t5_inst_done_seen", 32'(seen), 32'd1);
    step(); data_req = 1'b0;
    chk("t5_data_req", 32'(bus.mem_req), 32'd1);
    chk("t5_data_addr", bus.mem_addr, 32'h0000_3000);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      step();
      if (data_done) seen = 1;
    end
    chk("t5_data_done_seen", 32'(seen), 32'd1);
    chk("t5_data_rdata", data_rdata, 32'h0F0F_0F0F);

    // reset while waiting for load data
    addr_delay = 0; data_delay = 10; resp_rdata = 32'h7777_7777;
    step();
    data_req = 1'b1; data_wen = 4'b0; data_addr = 32'h0000_4000;
    step(); data_req = 1'b0;
    step();
    chk("t6_mav_busy", 32'(memory_available), 32'd0);
    rst = 1'b1;
    step(); rst = 1'b0;
    chk("t6_state", 32'(dbg_state), 32'd0);
    chk("t6_mav",   32'(memory_available), 32'd1);
    chk("t6_fav",   32'(fetch_available), 32'd1);
    chk("t6_req",   32'(bus.mem_req), 32'd0);
    chk("t6_rdata", data_rdata, 32'h0);
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (data_done) seen++;
    end
    chk("t6_no_done", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
